// File: rtl/processor.sv
// Multicycle 32-bit MiniSRC-subset core: 16 registers, one shared instruction/data
// memory port with read/write strobes and a ready handshake. Word addressed.
module processor #(
  parameter logic [31:0] START_PC = 32'd0
) (
  input  logic        iClk,
  input  logic        nRst,
  output logic [31:0] oMemAddr,
  output logic [31:0] oMemData,
  input  logic [31:0] iMemData,
  input  logic        iMemRdy,
  output logic        oMemRead,
  output logic        oMemWrite
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WRITEBACK,
    S_HALT
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] opa_q, opa_d;   // Rb value
  logic [31:0] opb_q, opb_d;   // Rc value
  logic [31:0] sto_q, sto_d;   // Ra value, store data
  logic [31:0] res_q, res_d;   // ALU result, effective address, or load data
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] rf_q [16];
  logic [31:0] rf_d [16];

  logic [4:0]  op;
  logic [3:0]  ra_idx, rb_idx, rc_idx;
  logic [31:0] imm;
  logic [31:0] alu_y;
  logic        wr_reg;
  logic        mem_rd, mem_wr;

  assign op     = ir_q[31:27];
  assign ra_idx = ir_q[26:23];
  assign rb_idx = ir_q[22:19];
  assign rc_idx = ir_q[18:15];
  assign imm    = {{13{ir_q[18]}}, ir_q[18:0]};

  // Unlisted opcodes fall to the default arm, so they neither compute nor write back.
  always_comb begin
    alu_y  = '0;
    wr_reg = 1'b0;
    case (op)
      OP_LD, OP_LDI, OP_ST, OP_ADDI: alu_y = opa_q + imm;
      OP_ADD:  alu_y = opa_q + opb_q;
      OP_SUB:  alu_y = opa_q - opb_q;
      OP_SHR:  alu_y = opa_q >> opb_q[4:0];
      OP_SHL:  alu_y = opa_q << opb_q[4:0];
      OP_AND:  alu_y = opa_q & opb_q;
      OP_OR:   alu_y = opa_q | opb_q;
      OP_ANDI: alu_y = opa_q & imm;
      OP_ORI:  alu_y = opa_q | imm;
      default: alu_y = '0;
    endcase
    case (op)
      OP_LD, OP_LDI, OP_ADD, OP_SUB, OP_SHR, OP_SHL,
      OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI: wr_reg = 1'b1;
      default: wr_reg = 1'b0;
    endcase
  end

  // NOTE: every signal written here gets a default first; a missed path would infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sto_d   = sto_q;
    res_d   = res_q;
    rf_d    = rf_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_rd = 1'b1;
        addr_d = pc_q;
        if (iMemRdy) begin
          ir_d    = iMemData;
          pc_d    = pc_q + 32'd1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        opa_d   = rf_q[rb_idx];
        opb_d   = rf_q[rc_idx];
        sto_d   = rf_q[ra_idx];
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        res_d = alu_y;
        if (op == OP_LD || op == OP_ST) state_d = S_MEM;
        else if (op == OP_HALT)         state_d = S_HALT;
        else                            state_d = S_WRITEBACK;
      end
      S_MEM: begin
        addr_d = res_q;
        if (op == OP_ST) begin
          mem_wr = 1'b1;
          data_d = sto_q;
        end else begin
          mem_rd = 1'b1;
        end
        if (iMemRdy) begin
          if (op == OP_LD) res_d = iMemData;
          state_d = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        if (wr_reg && ra_idx != 4'd0) rf_d[ra_idx] = res_q;
        state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // NOTE: the register file sits in the reset branch because it must read zero after reset.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state_q <= S_FETCH;
      pc_q    <= START_PC;
      ir_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      sto_q   <= '0;
      res_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rf_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sto_q   <= sto_d;
      res_q   <= res_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rf_q    <= rf_d;
    end
  end

  // NOTE: outputs are gated by nRst directly so strobes drop the instant reset asserts,
  // even though the reset state itself is FETCH.
  assign oMemRead  = nRst & mem_rd;
  assign oMemWrite = nRst & mem_wr;
  assign oMemAddr  = nRst ? addr_d : '0;
  assign oMemData  = nRst ? data_d : '0;

endmodule

// File: tb/tb_processor.sv
// Self-checking bench for processor: directed programs plus random programs, each
// compared against an instruction-level interpreter with a cycle-cost model.
module tb_processor;

  logic        iClk;
  logic        nRst;
  logic [31:0] oMemAddr, oMemData, iMemData;
  logic        iMemRdy, oMemRead, oMemWrite;

  logic [31:0] img [128];
  logic [31:0] mem [128];
  int          wait_n;
  int          cnt, acc_cnt, strobe_cyc, stab_err, cyc, last_done;
  logic        held, h_rd, h_wr;
  logic [31:0] h_addr, h_data;
  logic [31:0] got_addr[$], got_data[$], exp_addr[$], exp_data[$];
  int          exp_acc, exp_cycle;
  int          vectors, miscompares;

  processor #(.START_PC(32'd0)) dut (
    .iClk      (iClk),
    .nRst      (nRst),
    .oMemAddr  (oMemAddr),
    .oMemData  (oMemData),
    .iMemData  (iMemData),
    .iMemRdy   (iMemRdy),
    .oMemRead  (oMemRead),
    .oMemWrite (oMemWrite)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  assign iMemData = mem[oMemAddr[6:0]];

  always @(posedge iClk or negedge nRst) begin
    if (!nRst) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Memory model: ready after wait_n stalled cycles per access; all bookkeeping on negedge.
  always @(negedge iClk) begin
    if (!nRst) begin
      mem        <= img;
      cnt        <= 0;
      iMemRdy    <= (wait_n == 0);
      held       <= 1'b0;
      acc_cnt    <= 0;
      strobe_cyc <= 0;
      stab_err   <= 0;
      last_done  <= 0;
      got_addr.delete();
      got_data.delete();
    end else begin
      if (oMemRead && oMemWrite) stab_err <= stab_err + 1;
      else if (held && (oMemRead !== h_rd || oMemWrite !== h_wr || oMemAddr !== h_addr ||
                        (h_wr && oMemData !== h_data)))
        stab_err <= stab_err + 1;
      if (oMemRead || oMemWrite) begin
        strobe_cyc <= strobe_cyc + 1;
        if (cnt >= wait_n) begin
          iMemRdy   <= 1'b1;
          cnt       <= 0;
          held      <= 1'b0;
          acc_cnt   <= acc_cnt + 1;
          last_done <= cyc + 1;
          if (oMemWrite) begin
            mem[oMemAddr[6:0]] <= oMemData;
            got_addr.push_back(oMemAddr);
            got_data.push_back(oMemData);
          end
        end else begin
          iMemRdy <= 1'b0;
          cnt     <= cnt + 1;
          held    <= 1'b1;
          h_rd    <= oMemRead;
          h_wr    <= oMemWrite;
          h_addr  <= oMemAddr;
          h_data  <= oMemData;
        end
      end else begin
        iMemRdy <= (wait_n == 0);
        cnt     <= 0;
        held    <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [4:0] op, input int ra, input int rb, input int c);
    return {op, 4'(ra), 4'(rb), 19'(c)};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] op, input int ra, input int rb, input int rc);
    return {op, 4'(ra), 4'(rb), 4'(rc), 15'd0};
  endfunction

  // ISA interpreter: expected store stream, access count, and edge on which the halt fetch completes.
  task automatic model_run(input int w);
    logic [31:0] mm [128];
    logic [31:0] r [16];
    logic [31:0] pc, ins, a, b, c, ea, v;
    logic [4:0]  op;
    logic        wr;
    int          ra, t;
    mm = img;
    for (int i = 0; i < 16; i++) r[i] = 32'd0;
    pc = 32'd0; t = 0; exp_acc = 0; exp_cycle = -1;
    exp_addr.delete(); exp_data.delete();
    for (int k = 0; k < 500; k++) begin
      ins = mm[pc[6:0]];
      op  = ins[31:27];
      ra  = int'(ins[26:23]);
      a   = r[ins[22:19]];
      b   = r[ins[18:15]];
      c   = {{13{ins[18]}}, ins[18:0]};
      ea  = a + c;
      exp_acc++;
      t += 1 + w;
      if (op == 5'd27) begin
        exp_cycle = t;
        break;
      end
      pc = pc + 1;
      t += 3;
      wr = 1'b1;
      v  = 32'd0;
      case (op)
        5'd0:  begin v = mm[ea[6:0]]; exp_acc++; t += 1 + w; end
        5'd1:  v = ea;
        5'd2:  begin
                 mm[ea[6:0]] = r[ra];
                 exp_addr.push_back(ea);
                 exp_data.push_back(r[ra]);
                 exp_acc++; t += 1 + w; wr = 1'b0;
               end
        5'd3:  v = a + b;
        5'd4:  v = a - b;
        5'd5:  v = a >> b[4:0];
        5'd7:  v = a << b[4:0];
        5'd10: v = a & b;
        5'd11: v = a | b;
        5'd12: v = a + c;
        5'd13: v = a & c;
        5'd14: v = a | c;
        default: wr = 1'b0;
      endcase
      if (wr && ra != 0) r[ra] = v;
    end
  endtask

  task automatic run_prog(input string name, input int w);
    int snap;
    model_run(w);
    wait_n = w;
    nRst   = 1'b0;
    repeat (2) @(posedge iClk);
    #1;
    check({name, " rst read"},  {31'd0, oMemRead},  32'd0);
    check({name, " rst write"}, {31'd0, oMemWrite}, 32'd0);
    check({name, " rst addr"},  oMemAddr, 32'd0);
    check({name, " rst data"},  oMemData, 32'd0);
    @(posedge iClk);
    #1 nRst = 1'b1;
    #1;
    check({name, " first read"}, {31'd0, oMemRead}, 32'd1);
    check({name, " first addr"}, oMemAddr, 32'd0);
    for (int k = 0; k < 4000 && acc_cnt < exp_acc; k++) @(posedge iClk);
    check({name, " reached halt"}, {31'd0, acc_cnt >= exp_acc}, 32'd1);
    check({name, " halt cycle"}, last_done, exp_cycle);
    snap = strobe_cyc;
    repeat (20) @(posedge iClk);
    check({name, " accesses"}, acc_cnt, exp_acc);
    check({name, " quiet after halt"}, strobe_cyc, snap);
    check({name, " store count"}, got_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      check($sformatf("%s st%0d addr", name, i), got_addr[i], exp_addr[i]);
      check($sformatf("%s st%0d data", name, i), got_data[i], exp_data[i]);
    end
    check({name, " hold/exclusive"}, stab_err, 32'd0);
  endtask

  task automatic load_alu_prog();
    for (int i = 0; i < 128; i++) img[i] = 32'd0;
    img[0]  = enc_i(5'd12, 1, 0, 5);
    img[1]  = enc_i(5'd12, 2, 0, -3);
    img[2]  = enc_i(5'd12, 8, 0, 2);
    img[3]  = enc_r(5'd3, 3, 1, 2);
    img[4]  = enc_r(5'd4, 4, 1, 2);
    img[5]  = enc_r(5'd10, 5, 1, 2);
    img[6]  = enc_r(5'd11, 6, 1, 2);
    img[7]  = enc_r(5'd7, 7, 1, 8);
    for (int i = 0; i < 5; i++) img[8 + i] = enc_i(5'd2, 3 + i, 0, 30 + i);
    img[13] = enc_i(5'd27, 0, 0, 0);
  endtask

  task automatic check_alu_stores(input string name);
    logic [31:0] want [5];
    want = '{32'd2, 32'd8, 32'd5, 32'hFFFF_FFFD, 32'd20};
    check({name, " const count"}, got_addr.size(), 32'd5);
    for (int i = 0; i < 5 && i < got_addr.size(); i++) begin
      check($sformatf("%s const addr%0d", name, i), got_addr[i], 32'(30 + i));
      check($sformatf("%s const data%0d", name, i), got_data[i], want[i]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] pool [15];
    logic [31:0] ins;
    int n;
    vectors = 0; miscompares = 0;
    wait_n = 0;
    nRst = 1'b0;
    for (int i = 0; i < 128; i++) img[i] = 32'd0;
    #3;
    check("power-on read",  {31'd0, oMemRead},  32'd0);
    check("power-on write", {31'd0, oMemWrite}, 32'd0);

    // Load/shift/store program with an unassigned opcode word in the middle.
    img[0] = enc_i(5'd0, 3, 0, 20);
    img[1] = enc_i(5'd0, 7, 0, 21);
    img[2] = enc_i(5'd0, 2, 0, 22);
    img[3] = enc_r(5'd5, 4, 3, 7);
    img[4] = {5'b11111, 27'($urandom)};
    img[5] = enc_i(5'd2, 4, 0, 23);
    img[6] = enc_i(5'd27, 0, 0, 0);
    img[20] = 32'h22; img[21] = 32'h24; img[22] = 32'h28;
    run_prog("ldshr", 0);
    check("ldshr one write", got_addr.size(), 32'd1);
    if (got_addr.size() > 0) begin
      check("ldshr st addr", got_addr[0], 32'd23);
      check("ldshr st data", got_data[0], 32'd2);
    end

    load_alu_prog();
    run_prog("alu rdy1", 0);
    check_alu_stores("alu rdy1");
    run_prog("alu wait3", 3);
    check_alu_stores("alu wait3");

    pool = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd7, 5'd10, 5'd11,
             5'd12, 5'd13, 5'd14, 5'd26, 5'd31, 5'd9};
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 128; i++) img[i] = (i >= 64 && i < 96) ? $urandom : 32'd0;
      n = 8 + int'($urandom_range(0, 8));
      for (int i = 0; i < n; i++) begin
        ins = $urandom;
        ins[31:27] = pool[$urandom_range(0, 14)];
        if (ins[31:27] == 5'd0 || ins[31:27] == 5'd2) begin
          ins[22:19] = 4'd0;
          ins[18:0]  = 19'(64 + $urandom_range(0, 31));
        end
        img[i] = ins;
      end
      img[n] = enc_i(5'd27, 0, 0, 0);
      run_prog($sformatf("rand%0d", p), int'($urandom_range(0, 3)));
    end

    // Reset while a store strobe is being held by a slow memory.
    load_alu_prog();
    wait_n = 3;
    nRst = 1'b0;
    repeat (2) @(posedge iClk);
    #1 nRst = 1'b1;
    for (int k = 0; k < 2000 && !oMemWrite; k++) @(negedge iClk);
    check("midst saw write", {31'd0, oMemWrite}, 32'd1);
    #2 nRst = 1'b0;
    #1;
    check("midst read drop",  {31'd0, oMemRead},  32'd0);
    check("midst write drop", {31'd0, oMemWrite}, 32'd0);
    check("midst addr zero",  oMemAddr, 32'd0);
    check("midst no store",   got_addr.size(), 32'd0);
    @(posedge iClk);
    #1 nRst = 1'b1;
    #1;
    check("midst restart read", {31'd0, oMemRead}, 32'd1);
    check("midst restart pc",   oMemAddr, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
